// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if: handshake/operand bus of the multi-cycle ALU.
//   master (controller): drives start, op, srcA, srcB; observes busy, done,
//                        result, zero.
//   slave  (alu_mc)    : the reverse.
// -----------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (output start, op, srcA, srcB, input busy, done, result, zero);
  modport slave  (input start, op, srcA, srcB, output busy, done, result, zero);
endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc: multi-cycle ALU. Base ops (add/sub/logic/compare/shift) complete in
// one cycle; RV32M-style multiply/divide iterate one bit per cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any op in flight
//   bus   : alu_mc_if.slave (start/op/srcA/srcB in, busy/done/result/zero out)
// Optional feature macro ALU_MULDIV_EN: when defined the mul/div datapath and
// the CALC state are built; otherwise every op[4]=1 code returns 0 at
// latency 1.
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic             busy_q, done_q, zero_q;
  logic [WIDTH-1:0] result_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

  // ---------------- base ALU (single cycle) ----------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_res;
  assign shamt = bus.srcB[SHW-1:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    base_res = '0;
    case (bus.op[3:0])
      4'b0000: base_res = bus.srcA + bus.srcB;
      4'b0001: base_res = bus.srcA - bus.srcB;
      4'b0010: base_res = bus.srcA & bus.srcB;
      4'b0011: base_res = bus.srcA | bus.srcB;
      4'b0101: base_res = {{(WIDTH-1){1'b0}}, $signed(bus.srcA) < $signed(bus.srcB)};
      4'b0110: base_res = {{(WIDTH-1){1'b0}}, bus.srcA < bus.srcB};
      4'b0111: base_res = bus.srcA ^ bus.srcB;
      4'b1000: base_res = bus.srcA >> shamt;
      4'b1001: base_res = $signed(bus.srcA) >>> shamt;
      4'b1010: base_res = bus.srcA << shamt;
      default: base_res = '0;
    endcase
  end

  // Fast path: everything that finishes one cycle after acceptance.
  logic             fast;
  logic [WIDTH-1:0] fast_res;
  always_comb begin
    fast     = 1'b1;
    fast_res = '0;
    if (!bus.op[4]) begin
      fast_res = base_res;
    end
`ifdef ALU_MULDIV_EN
    else if (!bus.op[3]) begin
      if (bus.op[2] && bus.srcB == '0) begin
        // Divide by zero: quotient all ones, remainder is the dividend.
        fast_res = bus.op[1] ? bus.srcA : '1;
      end else if (bus.op[2] && !bus.op[0] && bus.srcA == MOST_NEG && bus.srcB == '1) begin
        // Signed overflow: quotient wraps to MOST_NEG, remainder 0.
        fast_res = bus.op[1] ? '0 : MOST_NEG;
      end else begin
        fast = 1'b0;
      end
    end
`endif
  end

`ifdef ALU_MULDIV_EN
  // ---------------- iterative mul/div datapath ----------------
  // acc_q holds {high, low}: for multiply {partial product, multiplier},
  // for divide {partial remainder, dividend/quotient}. mag_q holds the
  // multiplicand or divisor magnitude.
  logic [2:0]         md_op_q;
  logic               neg_q, rem_neg_q;
  logic [WIDTH-1:0]   mag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SHW-1:0]     cnt_q;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_signed = bus.op[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign b_signed = bus.op[2:0] inside {3'b001, 3'b100, 3'b110};
  assign a_neg    = a_signed & bus.srcA[WIDTH-1];
  assign b_neg    = b_signed & bus.srcB[WIDTH-1];
  assign a_mag    = a_neg ? -bus.srcA : bus.srcA;
  assign b_mag    = b_neg ? -bus.srcB : bus.srcB;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_d, prod;
  logic [WIDTH-1:0]   quot, rem, md_res;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    if (!md_op_q[2])
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};                              // add then shift right
    else if (!div_diff[WIDTH])
      acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};            // subtract fits
    else
      acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};           // restore
    prod = neg_q ? -acc_d : acc_d;
    quot = acc_d[WIDTH-1:0];
    rem  = acc_d[2*WIDTH-1:WIDTH];
    case (md_op_q)
      3'b000:                 md_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         md_res = neg_q ? -quot : quot;
      default:                md_res = rem_neg_q ? -rem : rem;
    endcase
  end
`endif

  // ---------------- control FSM with registered outputs ----------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
`ifdef ALU_MULDIV_EN
      // NOTE: datapath registers are reset too, so an aborted op leaves no
      // partial state behind.
      md_op_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (fast) begin
              result_q <= fast_res;
              zero_q   <= (fast_res == '0);
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
`ifdef ALU_MULDIV_EN
            else begin
              md_op_q   <= bus.op[2:0];
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              mag_q     <= bus.op[2] ? b_mag : a_mag;
              acc_q     <= {{WIDTH{1'b0}}, (bus.op[2] ? a_mag : b_mag)};
              cnt_q     <= '0;
              state_q   <= CALC;
            end
`endif
          end
        end
`ifdef ALU_MULDIV_EN
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            result_q <= md_res;
            zero_q   <= (md_res == '0);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=32). A behavioural model
// computes result and latency with 64-bit arithmetic; every cycle of each op
// busy/done/result/zero are compared against it. Directed literals pin the
// model, then randomized ops follow. Honours ALU_MULDIV_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] last_res = '0;

  alu_mc_if #(.WIDTH(32)) bus_if ();
  alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (!op[4]) begin
      case (op[3:0])
        4'd0:    return a + b;
        4'd1:    return a - b;
        4'd2:    return a & b;
        4'd3:    return a | b;
        4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd6:    return (a < b) ? 32'd1 : 32'd0;
        4'd7:    return a ^ b;
        4'd8:    return a >> b[4:0];
        4'd9:    return $signed(a) >>> b[4:0];
        4'd10:   return a << b[4:0];
        default: return 32'd0;
      endcase
    end
`ifdef ALU_MULDIV_EN
    if (op[3]) return 32'd0;
    case (op[2:0])
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return op[1] ? 32'd0 : 32'h8000_0000;
        case (op[1:0])
          2'b00:   p = sa / sb;
          2'b01:   p = ua / ub;
          2'b10:   p = sa % sb;
          default: p = ua % ub;
        endcase
        return p[31:0];
      end
    endcase
`else
    return 32'd0;
`endif
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef ALU_MULDIV_EN
    if (!op[4] || op[3]) return 1;
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge and follow it through the idle cycle after done.
  // poke>0 raises start with ADD 1,1 after sampling that cycle (must be ignored).
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input bit use_lit, input int poke);
    logic [31:0] exp_res;
    int lat;
    string tag;
    exp_res = use_lit ? lit : model(op, a, b);
    lat     = model_lat(op, a, b);
    tag     = $sformatf("op%02h(%08h,%08h)", op, a, b);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.srcA  = a;
    bus_if.srcB  = b;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      check({tag, " busy"}, bus_if.busy, (k <= lat));
      check({tag, " done"}, bus_if.done, (k == lat));
      if (k == lat) begin
        check({tag, " result"}, bus_if.result, exp_res);
        check({tag, " zero"}, bus_if.zero, (exp_res == 32'd0));
        last_res = exp_res;
      end else begin
        check({tag, " held"}, bus_if.result, last_res);
      end
      if (k == poke) begin
        bus_if.start = 1'b1;
        bus_if.op    = 5'd0;
        bus_if.srcA  = 32'd1;
        bus_if.srcB  = 32'd1;
      end else begin
        bus_if.start = 1'b0;
        bus_if.op    = 5'($urandom);
        bus_if.srcA  = $urandom;
        bus_if.srcB  = $urandom;
      end
    end
    bus_if.start = 1'b0;
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bus_if.start = 1'b0;
    bus_if.op    = '0;
    bus_if.srcA  = '0;
    bus_if.srcB  = '0;
    repeat (2) @(negedge clk);
    check("reset busy", bus_if.busy, 1'b0);
    check("reset done", bus_if.done, 1'b0);
    check("reset result", bus_if.result, 32'd0);
    check("reset zero", bus_if.zero, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(5'h00, 32'd5, 32'd7, 32'd12, 1'b1, 0);
`ifdef ALU_MULDIV_EN
    // Abort a DIV 20 cycles into CALC.
    bus_if.start = 1'b1;
    bus_if.op    = 5'h14;
    bus_if.srcA  = 32'd1000;
    bus_if.srcB  = 32'd3;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (19) @(negedge clk);
    check("midcalc busy", bus_if.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort busy", bus_if.busy, 1'b0);
    check("abort done", bus_if.done, 1'b0);
    check("abort result", bus_if.result, 32'd0);
    check("abort zero", bus_if.zero, 1'b1);
    last_res = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(5'h00, 32'd5, 32'd7, 32'd12, 1'b1, 0);
`endif

    run_op(5'h01, 32'd9, 32'd9, 32'd0, 1'b1, 0);
    run_op(5'h09, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b1, 0);
    run_op(5'h06, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 0);
    run_op(5'h05, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run_op(5'h04, 32'd3, 32'd4, 32'd0, 1'b1, 0);

`ifdef ALU_MULDIV_EN
    run_op(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
    run_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
    run_op(5'h14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, 0);
    run_op(5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(5'h15, 32'd100, 32'd7, 32'd14, 1'b1, 0);
    run_op(5'h17, 32'd100, 32'd7, 32'd2, 1'b1, 0);
    run_op(5'h15, 32'd10, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(5'h17, 32'd10, 32'd0, 32'd10, 1'b1, 0);
    run_op(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
    run_op(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run_op(5'h12, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(5'h18, 32'd3, 32'd4, 32'd0, 1'b1, 0);
    run_op(5'h10, 32'd123457, 32'd98765, 32'd0, 1'b0, 5);
`else
    run_op(5'h10, 32'd3, 32'd4, 32'd0, 1'b1, 0);
    run_op(5'h14, 32'd10, 32'd0, 32'd0, 1'b1, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 40));
        3:       begin ra = 32'($urandom_range(0, 3)); rb = $urandom; end
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 32'd0, 1'b0, (n % 7 == 0) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
